pool2d_engine: RTL
==================

Name: pool2d_engine

Overview:
- Parametrised 2x2/stride-2 pooling engine: the next generation of the max-pool datapath.
- Reads a packed multi-channel feature map from a source SRAM and writes the pooled map to a destination SRAM.
- Runtime feature-map dimensions, base addresses and max/average mode; compile-time lane width and channel count.
- Sits between the GBUFF source and destination SRAMs, under a start/done handshake from the top-level controller.

Parameters:
DW, 8, bits per channel lane (signed two's complement)
CH, 4, channel lanes packed per SRAM word (word = CH*DW bits, lane i at bits [i*DW +: DW])
AW, 16, SRAM word-address width
DIMW, 10, width of height/width configuration fields

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
start  in  1  start request, sampled only in IDLE
mode  in  1  0 = max pooling, 1 = average pooling; sampled with start
in_h  in  DIMW  input rows; sampled with start
in_w  in  DIMW  input columns (words per row); sampled with start
src_base  in  AW  source map base word address; sampled with start
dst_base  in  AW  destination map base word address; sampled with start
src_addr  out  AW  source SRAM read address (registered)
src_rdata  in  CH*DW  source SRAM read data, 1-cycle synchronous read latency
dst_wen  out  1  destination write enable (one-cycle pulse per output word)
dst_addr  out  AW  destination write address
dst_wdata  out  CH*DW  destination write data
busy  out  1  high while a job is running
done  out  1  one-cycle pulse at job completion

Behaviour:
- Reset values: src_addr=0, dst_wen=0, dst_addr=0, dst_wdata=0, busy=0, done=0, FSM=IDLE, all counters 0.
- rst asserted mid-job aborts immediately: the job is not resumed, no further writes, and the next job starts cleanly.
- Start handshake:
  - In IDLE, start=1 at a clock edge latches all cfg inputs, sets busy=1 and enters F0.
  - start is ignored while busy.
- Output size: out_h = in_h>>1, out_w = in_w>>1. Odd trailing row/column are dropped.
- If out_h==0 or out_w==0: go IDLE -> DONE. No SRAM access; done pulses in the cycle after start is accepted.
- Output pixel (r,c) is produced in raster order (c fastest). Each pixel takes exactly 6 states:
  - F0: src_addr = A(2r,2c).
  - F1: src_addr = A(2r,2c+1); capture d0.
  - F2: src_addr = A(2r+1,2c); capture d1.
  - F3: src_addr = A(2r+1,2c+1); capture d2.
  - RES: capture d3; compute result.
  - WR: dst_wen=1, dst_addr = dst_base + r*out_w + c, dst_wdata = result.
- src_addr is registered so it is valid throughout the named state.
- Address rules:
  - A(y,x) = src_base + y*in_w + x.
  - All address arithmetic is modulo 2^AW (wrap-around, no error).
- After WR: if (r,c) is the last pixel go to DONE, otherwise go to F0 of the next pixel.
- DONE: done=1 and busy=0 for one cycle, then IDLE. A start in IDLE the following cycle is accepted.
- Per-lane arithmetic (independent lanes, no cross-lane carry):
  - Max mode: signed maximum of the 4 values.
  - Avg mode: signed sum in DW+2 bits, arithmetic right shift by 2 (floor toward -inf), truncated to DW.
- dst_wen is 0 in every state except WR. dst_addr and dst_wdata hold their last value outside WR.
- Job latency: 6*out_h*out_w cycles of F0..WR. done asserts in the cycle after the final WR.

Test Plan:
- Single pixel, max mode, in_h=in_w=2, CH=4, DW=8, bases 0: lane0 = {3,-5,7,1}, lane1 = {-128,-1,-2,-100} -> exactly one write at addr 0 with lane0=7, lane1=-1; src_addr sequence 0,1,2,3; done 7 cycles after start.
- Avg mode, same geometry: lane0 = {1,2,3,4} -> 2; lane1 = {-1,-2,-3,-4} -> -3 (floor); lane2 = {127,127,127,127} -> 127 (no overflow).
- Multi-pixel: in_h=4, in_w=6, src_base=0x100, dst_base=0x200 -> 6 writes to 0x200..0x205 in order; pixel (1,2) reads 0x110, 0x111, 0x116, 0x117; done 37 cycles after start; busy high for 36 cycles.
- Odd and degenerate dims:
  - in_h=3, in_w=5 -> 2 writes; row 2 and column 4 never addressed.
  - in_h=1 -> no reads or writes; done 1 cycle after start.
- Address wrap: src_base=0xFFFE, in_w=2 -> reads 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Control robustness:
  - start held high and re-pulsed mid-job -> no restart, cfg unchanged.
  - rst low during F2 of pixel 3 -> all outputs 0 immediately.
  - New job after release -> correct, full write sequence.

Source files
------------

// File: rtl/pool2d_engine_if.sv
// Bundle of start/config, source-read and destination-write signals for the
// 2x2/stride-2 pooling engine. The master side is the controller plus the two
// SRAMs (it supplies config and read data); the slave side is the engine.
interface pool2d_engine_if #(
    parameter int DW   = 8,
    parameter int CH   = 4,
    parameter int AW   = 16,
    parameter int DIMW = 10
);
    logic                 start;
    logic                 mode;
    logic [DIMW-1:0]      in_h;
    logic [DIMW-1:0]      in_w;
    logic [AW-1:0]        src_base;
    logic [AW-1:0]        dst_base;
    logic [AW-1:0]        src_addr;
    logic [CH*DW-1:0]     src_rdata;
    logic                 dst_wen;
    logic [AW-1:0]        dst_addr;
    logic [CH*DW-1:0]     dst_wdata;
    logic                 busy;
    logic                 done;

    modport master (
        output start, mode, in_h, in_w, src_base, dst_base, src_rdata,
        input  src_addr, dst_wen, dst_addr, dst_wdata, busy, done
    );

    modport slave (
        input  start, mode, in_h, in_w, src_base, dst_base, src_rdata,
        output src_addr, dst_wen, dst_addr, dst_wdata, busy, done
    );
endinterface

// File: rtl/pool2d_engine.sv
// 2x2 / stride-2 pooling engine (max or floor-average per signed lane).
// Each output pixel walks six states: four source reads (F0..F3), a result
// state that captures the last word, and a single destination write (WR).
module pool2d_engine #(
    parameter int DW   = 8,
    parameter int CH   = 4,
    parameter int AW   = 16,
    parameter int DIMW = 10
) (
    input  logic             clk,
    input  logic             rst,
    pool2d_engine_if.slave   bus
);

    localparam int WW = CH * DW;
    localparam logic [DIMW-1:0] DIM_ONE  = DIMW'(1);
    localparam logic [AW-1:0]   ADDR_ONE = AW'(1);
    localparam logic [AW-1:0]   ADDR_TWO = AW'(2);

    typedef enum logic [2:0] {
        S_IDLE, S_F0, S_F1, S_F2, S_F3, S_RES, S_WR, S_DONE
    } state_t;

    state_t          state_reg, state_next;
    logic            mode_reg, mode_next;
    logic [AW-1:0]   in_w_reg, in_w_next;          // row pitch, zero-extended
    logic [DIMW-1:0] out_h_reg, out_h_next;
    logic [DIMW-1:0] out_w_reg, out_w_next;
    logic [DIMW-1:0] row_cnt_reg, row_cnt_next;
    logic [DIMW-1:0] col_cnt_reg, col_cnt_next;
    logic [AW-1:0]   row_addr_reg, row_addr_next;  // A(2r, 0)
    logic [AW-1:0]   pix_addr_reg, pix_addr_next;  // A(2r, 2c)
    logic [AW-1:0]   dst_ptr_reg, dst_ptr_next;    // dst_base + r*out_w + c
    logic [AW-1:0]   src_addr_reg, src_addr_next;
    logic [WW-1:0]   d0_reg, d0_next;
    logic [WW-1:0]   d1_reg, d1_next;
    logic [WW-1:0]   d2_reg, d2_next;
    logic            dst_wen_reg, dst_wen_next;
    logic [AW-1:0]   dst_addr_reg, dst_addr_next;
    logic [WW-1:0]   dst_wdata_reg, dst_wdata_next;

    logic [WW-1:0]   result_w;

    // Per-lane pooling; the fourth sample comes straight from the SRAM read
    // port in RES, so no d3 register is needed.
    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_lane
            logic signed [DW-1:0]   a_w, b_w, c_w, d_w;
            logic signed [DW-1:0]   m01_w, m23_w, max_w;
            logic signed [DW+1:0]   sum_w;

            assign a_w   = d0_reg[gi*DW +: DW];
            assign b_w   = d1_reg[gi*DW +: DW];
            assign c_w   = d2_reg[gi*DW +: DW];
            assign d_w   = bus.src_rdata[gi*DW +: DW];
            assign m01_w = (a_w > b_w) ? a_w : b_w;
            assign m23_w = (c_w > d_w) ? c_w : d_w;
            assign max_w = (m01_w > m23_w) ? m01_w : m23_w;
            // Two guard bits make the four-term sum exact; >>> floors.
            assign sum_w = {{2{a_w[DW-1]}}, a_w} + {{2{b_w[DW-1]}}, b_w}
                         + {{2{c_w[DW-1]}}, c_w} + {{2{d_w[DW-1]}}, d_w};
            assign result_w[gi*DW +: DW] = mode_reg ? DW'(sum_w >>> 2) : max_w;
        end
    endgenerate

    // State and datapath registers, cleared asynchronously so an abort
    // leaves nothing half-done for the next job.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= S_IDLE;
            mode_reg      <= 1'b0;
            in_w_reg      <= '0;
            out_h_reg     <= '0;
            out_w_reg     <= '0;
            row_cnt_reg   <= '0;
            col_cnt_reg   <= '0;
            row_addr_reg  <= '0;
            pix_addr_reg  <= '0;
            dst_ptr_reg   <= '0;
            src_addr_reg  <= '0;
            d0_reg        <= '0;
            d1_reg        <= '0;
            d2_reg        <= '0;
            dst_wen_reg   <= 1'b0;
            dst_addr_reg  <= '0;
            dst_wdata_reg <= '0;
        end else begin
            state_reg     <= state_next;
            mode_reg      <= mode_next;
            in_w_reg      <= in_w_next;
            out_h_reg     <= out_h_next;
            out_w_reg     <= out_w_next;
            row_cnt_reg   <= row_cnt_next;
            col_cnt_reg   <= col_cnt_next;
            row_addr_reg  <= row_addr_next;
            pix_addr_reg  <= pix_addr_next;
            dst_ptr_reg   <= dst_ptr_next;
            src_addr_reg  <= src_addr_next;
            d0_reg        <= d0_next;
            d1_reg        <= d1_next;
            d2_reg        <= d2_next;
            dst_wen_reg   <= dst_wen_next;
            dst_addr_reg  <= dst_addr_next;
            dst_wdata_reg <= dst_wdata_next;
        end
    end

    // Next-state and next-register logic. Addresses are computed one state
    // early so the registered src_addr is valid for the whole named state.
    always_comb begin
        state_next     = state_reg;
        mode_next      = mode_reg;
        in_w_next      = in_w_reg;
        out_h_next     = out_h_reg;
        out_w_next     = out_w_reg;
        row_cnt_next   = row_cnt_reg;
        col_cnt_next   = col_cnt_reg;
        row_addr_next  = row_addr_reg;
        pix_addr_next  = pix_addr_reg;
        dst_ptr_next   = dst_ptr_reg;
        src_addr_next  = src_addr_reg;
        d0_next        = d0_reg;
        d1_next        = d1_reg;
        d2_next        = d2_reg;
        dst_wen_next   = 1'b0;
        dst_addr_next  = dst_addr_reg;
        dst_wdata_next = dst_wdata_reg;

        case (state_reg)
            S_IDLE: begin
                if (bus.start) begin
                    mode_next     = bus.mode;
                    in_w_next     = AW'(bus.in_w);
                    out_h_next    = bus.in_h >> 1;
                    out_w_next    = bus.in_w >> 1;
                    row_cnt_next  = '0;
                    col_cnt_next  = '0;
                    row_addr_next = bus.src_base;
                    pix_addr_next = bus.src_base;
                    dst_ptr_next  = bus.dst_base;
                    // Empty output: skip straight to DONE without touching
                    // the source address.
                    if (((bus.in_h >> 1) == '0) || ((bus.in_w >> 1) == '0)) begin
                        state_next = S_DONE;
                    end else begin
                        src_addr_next = bus.src_base;
                        state_next    = S_F0;
                    end
                end
            end
            S_F0: begin
                src_addr_next = src_addr_reg + ADDR_ONE;
                state_next    = S_F1;
            end
            S_F1: begin
                d0_next       = bus.src_rdata;
                // Step from (2r,2c+1) down one row and back one column.
                src_addr_next = src_addr_reg + in_w_reg - ADDR_ONE;
                state_next    = S_F2;
            end
            S_F2: begin
                d1_next       = bus.src_rdata;
                src_addr_next = src_addr_reg + ADDR_ONE;
                state_next    = S_F3;
            end
            S_F3: begin
                d2_next    = bus.src_rdata;
                state_next = S_RES;
            end
            S_RES: begin
                dst_wen_next   = 1'b1;
                dst_addr_next  = dst_ptr_reg;
                dst_wdata_next = result_w;
                dst_ptr_next   = dst_ptr_reg + ADDR_ONE;
                state_next     = S_WR;
            end
            S_WR: begin
                if (col_cnt_reg == (out_w_reg - DIM_ONE)) begin
                    if (row_cnt_reg == (out_h_reg - DIM_ONE)) begin
                        state_next = S_DONE;
                    end else begin
                        row_cnt_next  = row_cnt_reg + DIM_ONE;
                        col_cnt_next  = '0;
                        row_addr_next = row_addr_reg + (in_w_reg << 1);
                        pix_addr_next = row_addr_reg + (in_w_reg << 1);
                        src_addr_next = row_addr_reg + (in_w_reg << 1);
                        state_next    = S_F0;
                    end
                end else begin
                    col_cnt_next  = col_cnt_reg + DIM_ONE;
                    pix_addr_next = pix_addr_reg + ADDR_TWO;
                    src_addr_next = pix_addr_reg + ADDR_TWO;
                    state_next    = S_F0;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign bus.src_addr  = src_addr_reg;
    assign bus.dst_wen   = dst_wen_reg;
    assign bus.dst_addr  = dst_addr_reg;
    assign bus.dst_wdata = dst_wdata_reg;
    assign bus.busy      = (state_reg != S_IDLE) && (state_reg != S_DONE);
    assign bus.done      = (state_reg == S_DONE);

endmodule
